// File: rtl/vc_uart_if.sv
// Register-bus bundle between the core's I/O path and vc_uart.
interface vc_uart_if;
    logic [3:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] rdata;

    modport master (output reg_addr, reg_data, reg_write, reg_read, input rdata);
    modport slave  (input reg_addr, reg_data, reg_write, reg_read, output rdata);
endinterface

// File: rtl/vc_uart.sv
// Memory-mapped 8N1 UART with programmable divisor and level interrupt.
// Define VC_UART_RX_EN to build the receiver; without it only TX exists.
module vc_uart #(
    parameter int DIV_W     = 12,
    parameter int RESET_DIV = 103
) (
    input  logic     clk,
    input  logic     reset,
    vc_uart_if.slave bus,
    input  logic     rx,
    output logic     tx,
    output logic     irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    localparam logic [3:0] A_DATA   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_DIV_LO = 4'd2;
    localparam logic [3:0] A_DIV_HI = 4'd3;
    localparam logic [3:0] A_CTRL   = 4'd4;

    logic [DIV_W-1:0] div;
    logic [15:0]      div_ext;
    logic             tx_irq_en, rx_irq_en;
    logic             wr_data, wr_div_lo, wr_div_hi, wr_ctrl;

    assign div_ext   = 16'(div);
    assign wr_data   = bus.reg_write && (bus.reg_addr == A_DATA);
    assign wr_div_lo = bus.reg_write && (bus.reg_addr == A_DIV_LO);
    assign wr_div_hi = bus.reg_write && (bus.reg_addr == A_DIV_HI);
    assign wr_ctrl   = bus.reg_write && (bus.reg_addr == A_CTRL);

    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= DIV_W'(RESET_DIV);
            tx_irq_en <= 1'b0;
        end else begin
            if (wr_div_lo) div <= DIV_W'({div_ext[15:8], bus.reg_data});
            if (wr_div_hi) div <= DIV_W'({bus.reg_data, div_ext[7:0]});
            if (wr_ctrl)   tx_irq_en <= bus.reg_data[0];
        end
    end

    // ---- transmitter: holding register feeding a 10-bit frame shifter
    uart_state_t      tx_st, tx_nxt;
    logic [DIV_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_sh, hold_data;
    logic             hold_full, tx_load, tx_bit_end, tx_ready, tx_idle;

    assign tx_bit_end = (tx_cnt == '0);
    assign tx_ready   = !hold_full;
    assign tx_idle    = !hold_full && (tx_st == ST_IDLE);

    always_comb begin
        tx_nxt  = tx_st;
        tx_load = 1'b0;
        case (tx_st)
            ST_IDLE:  if (hold_full) begin
                          tx_nxt  = ST_START;
                          tx_load = 1'b1;
                      end
            ST_START: if (tx_bit_end) tx_nxt = ST_DATA;
            ST_DATA:  if (tx_bit_end && (tx_idx == 3'd7)) tx_nxt = ST_STOP;
            ST_STOP:  if (tx_bit_end) begin
                          // Chain straight into the next start bit when a byte is waiting.
                          tx_nxt  = hold_full ? ST_START : ST_IDLE;
                          tx_load = hold_full;
                      end
            default:  tx_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st     <= ST_IDLE;
            hold_full <= 1'b0;
            tx        <= 1'b1;
        end else begin
            tx_st <= tx_nxt;
            if (wr_data && !hold_full) hold_full <= 1'b1;
            else if (tx_load)          hold_full <= 1'b0;
            tx <= (tx_st == ST_START) ? 1'b0 : (tx_st == ST_DATA) ? tx_sh[0] : 1'b1;
        end
    end

    // Counter reloads continuously in IDLE so a new DIV applies from the next bit only.
    always_ff @(posedge clk) begin
        if (wr_data && !hold_full) hold_data <= bus.reg_data;
        if ((tx_st == ST_IDLE) || tx_bit_end) tx_cnt <= div;
        else                                  tx_cnt <= tx_cnt - DIV_W'(1);
        if (tx_load) begin
            tx_sh  <= hold_data;
            tx_idx <= 3'd0;
        end else if ((tx_st == ST_DATA) && tx_bit_end) begin
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 3'd1;
        end
    end

    // ---- receiver
    logic       rx_valid, rx_overrun, frame_err;
    logic [7:0] rx_data;

`ifdef VC_UART_RX_EN
    uart_state_t      rx_st, rx_nxt;
    logic [1:0]       rx_sync;
    logic [DIV_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_sh;
    logic             rx_s, rx_bit_end, rx_done, rx_store, rx_accept, rd_pop, wr_status;

    assign rx_s       = rx_sync[1];
    assign rx_bit_end = (rx_cnt == '0);
    assign rd_pop     = bus.reg_read && (bus.reg_addr == A_DATA);
    assign wr_status  = bus.reg_write && (bus.reg_addr == A_STATUS);
    assign rx_store   = rx_done && rx_s;
    assign rx_accept  = rx_store && (!rx_valid || rd_pop);

    always_comb begin
        rx_nxt  = rx_st;
        rx_done = 1'b0;
        case (rx_st)
            ST_IDLE:  if (!rx_s) rx_nxt = ST_START;
            ST_START: if (rx_bit_end) rx_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_bit_end && (rx_idx == 3'd7)) rx_nxt = ST_STOP;
            ST_STOP:  if (rx_bit_end) begin
                          rx_nxt  = ST_IDLE;
                          rx_done = 1'b1;
                      end
            default:  rx_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st      <= ST_IDLE;
            rx_sync    <= 2'b11;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_irq_en  <= 1'b0;
        end else begin
            rx_st   <= rx_nxt;
            rx_sync <= {rx_sync[0], rx};
            if (wr_ctrl) rx_irq_en <= bus.reg_data[1];
            // Clears first so a coincident set takes priority.
            if (wr_status && bus.reg_data[3]) rx_overrun <= 1'b0;
            if (wr_status && bus.reg_data[4]) frame_err  <= 1'b0;
            if (rd_pop)                       rx_valid   <= 1'b0;
            if (rx_done && !rx_s)             frame_err  <= 1'b1;
            if (rx_accept)                    rx_valid   <= 1'b1;
            else if (rx_store)                rx_overrun <= 1'b1;
        end
    end

    // Half-bit wait in IDLE/START centres every later sample in its bit.
    always_ff @(posedge clk) begin
        if (rx_st == ST_IDLE) rx_cnt <= div >> 1;
        else if (rx_bit_end)  rx_cnt <= div;
        else                  rx_cnt <= rx_cnt - DIV_W'(1);
        if (rx_st != ST_DATA) rx_idx <= 3'd0;
        else if (rx_bit_end) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
        end
        if (rx_accept) rx_data <= rx_sh;
    end
`else
    logic unused_rx;
    assign unused_rx  = &{1'b0, rx, bus.reg_read};
    assign rx_valid   = 1'b0;
    assign rx_overrun = 1'b0;
    assign frame_err  = 1'b0;
    assign rx_data    = 8'h00;
    assign rx_irq_en  = 1'b0;
`endif

    always_comb begin
        bus.rdata = 8'h00;
        case (bus.reg_addr)
            A_DATA:   bus.rdata = rx_data;
            A_STATUS: bus.rdata = {3'b000, frame_err, rx_overrun, rx_valid, tx_idle, tx_ready};
            A_DIV_LO: bus.rdata = div_ext[7:0];
            A_DIV_HI: bus.rdata = div_ext[15:8];
            A_CTRL:   bus.rdata = {6'b000000, rx_irq_en, tx_irq_en};
            default:  bus.rdata = 8'h00;
        endcase
    end

    assign irq = (tx_irq_en && tx_ready) || (rx_irq_en && rx_valid);
endmodule

// File: tb/tb_vc_uart.sv
// Randomised bench for vc_uart: serial frames are predicted from the byte value and DIV.
module tb_vc_uart;
    localparam int DIV_W     = 12;
    localparam int RESET_DIV = 103;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic tx;
    logic irq;
    int   n_checks = 0;
    int   n_errors = 0;

    vc_uart_if bus();

    vc_uart #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
        .clk(clk), .reset(reset), .bus(bus), .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.reg_addr  = a;
        bus.reg_data  = d;
        bus.reg_write = 1'b1;
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.reg_addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic reg_pop(output logic [7:0] d);
        @(negedge clk);
        bus.reg_addr = 4'd0;
        bus.reg_read = 1'b1;
        #1;
        d = bus.rdata;
        @(posedge clk);
        #1;
        bus.reg_read = 1'b0;
    endtask

    task automatic set_div(input int d);
        reg_wr(4'd2, 8'(d));
        reg_wr(4'd3, 8'(d >> 8));
    endtask

    // Reference frame: start 0, eight data bits LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] b, input int d);
        for (int k = 0; k < 10; k++) begin
            logic [15:0] got;
            logic [15:0] exp;
            got = '0;
            for (int j = 0; j <= d; j++) begin
                @(negedge clk);
                got[j] = tx;
            end
            exp = frame_bit(b, k) ? 16'((1 << (d + 1)) - 1) : 16'h0000;
            check($sformatf("%s bit%0d", tag, k), 32'(got), 32'(exp));
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        int high;
        high = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx === 1'b1) high++;
        end
        check(tag, 32'(high), 32'(n));
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [7:0] s;
        for (int i = 0; i < 3000; i++) begin
            reg_rd(4'd1, s);
            if (s[1]) break;
        end
        check(tag, 32'(s[1]), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            repeat (d + 1) begin
                @(negedge clk);
                rx = v;
            end
        end
        repeat (3 * (d + 1)) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic wait_rx_valid(input string tag);
        logic [7:0] s;
        for (int i = 0; i < 200; i++) begin
            reg_rd(4'd1, s);
            if (s[2]) break;
        end
        check(tag, 32'(s[2]), 32'd1);
    endtask

    initial begin
        logic [7:0] st, rd, b, b1, b2, b3, s;
        int d;
        reset = 1'b1;
        rx = 1'b1;
        bus.reg_addr = '0;
        bus.reg_data = '0;
        bus.reg_write = 1'b0;
        bus.reg_read = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset irq", 32'(irq), 32'd0);
        reg_rd(4'd1, st); check("reset status", 32'(st), 32'h03);
        reg_rd(4'd2, rd); check("reset div_lo", 32'(rd), 32'(RESET_DIV & 8'hFF));
        reg_rd(4'd3, rd); check("reset div_hi", 32'(rd), 32'(RESET_DIV >> 8));
        reg_rd(4'd4, rd); check("reset ctrl", 32'(rd), 32'd0);

        for (int t = 0; t < 3; t++) begin
            d = (t == 0) ? 3 : int'($urandom_range(1, 4));
            b = (t == 0) ? 8'hA5 : 8'($urandom);
            set_div(d);
            reg_wr(4'd0, b);
            reg_rd(4'd1, st);
            check("tx_ready after write", 32'(st[0]), 32'd0);
            check("tx high before load", 32'(tx), 32'd1);
            @(posedge clk);
            reg_rd(4'd1, st);
            check("tx_ready after load", 32'(st[0]), 32'd1);
            check("tx high before start", 32'(tx), 32'd1);
            @(posedge clk);
            check_frame("single", b, d);
            @(posedge clk);
            reg_rd(4'd1, st);
            check("status after single", 32'(st), 32'h03);
        end

        d = int'($urandom_range(1, 4));
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        set_div(d);
        fork
            begin
                reg_wr(4'd0, b1);
                for (int i = 0; i < 8; i++) begin
                    reg_rd(4'd1, s);
                    if (s[0]) break;
                end
                check("b2b ready for second", 32'(s[0]), 32'd1);
                reg_wr(4'd0, b2);
                reg_rd(4'd1, s);
                check("b2b ready while full", 32'(s[0]), 32'd0);
                reg_wr(4'd0, b3);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk);
                    #1;
                    if (!tx) break;
                end
                check("b2b start seen", 32'(tx), 32'd0);
                check_frame("b2b first", b1, d);
                check_frame("b2b second", b2, d);
                check_idle("b2b third dropped", 3 * (d + 1));
            end
        join
        reg_rd(4'd1, st); check("status after b2b", 32'(st), 32'h03);

        set_div(2);
        reg_wr(4'd4, 8'h01);
        @(negedge clk); check("irq tx_ready", 32'(irq), 32'd1);
        reg_wr(4'd0, 8'($urandom));
        @(negedge clk); check("irq while holding full", 32'(irq), 32'd0);
        @(negedge clk); check("irq after load", 32'(irq), 32'd1);
        reg_wr(4'd4, 8'h00);
        @(negedge clk); check("irq disabled", 32'(irq), 32'd0);
        wait_tx_idle("idle after irq test");

        reg_wr(4'd9, 8'hFF);
        reg_rd(4'd9, rd); check("unmapped read", 32'(rd), 32'd0);
        reg_rd(4'd4, rd); check("ctrl after unmapped write", 32'(rd), 32'd0);
        reg_wr(4'd3, 8'hFF);
        reg_rd(4'd3, rd); check("div_hi width", 32'(rd), 32'h0F);
        reg_wr(4'd4, 8'h03);
        reg_rd(4'd4, rd);
`ifdef VC_UART_RX_EN
        check("ctrl readback", 32'(rd), 32'h03);
`else
        check("ctrl readback", 32'(rd), 32'h01);
`endif
        reg_wr(4'd4, 8'h00);

`ifdef VC_UART_RX_EN
        set_div(3);
        reg_wr(4'd4, 8'h02);
        @(negedge clk); check("rx irq before byte", 32'(irq), 32'd0);
        send_rx(8'h3C, 1'b1, 3);
        wait_rx_valid("rx valid 0x3C");
        check("rx irq on valid", 32'(irq), 32'd1);
        reg_pop(rd); check("rx data 0x3C", 32'(rd), 32'h3C);
        @(negedge clk); check("rx irq after pop", 32'(irq), 32'd0);
        reg_rd(4'd1, st); check("status after pop", 32'(st), 32'h03);

        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom); b = 8'($urandom);
        send_rx(b1, 1'b1, 3);
        send_rx(b2, 1'b1, 3);
        wait_rx_valid("rx valid overrun");
        reg_rd(4'd1, st); check("status overrun", 32'(st), 32'h0F);
        reg_pop(rd); check("rx keeps old byte", 32'(rd), 32'(b1));
        reg_rd(4'd1, st); check("overrun sticky", 32'(st), 32'h0B);
        send_rx(b3, 1'b1, 3);
        wait_rx_valid("rx valid third");
        send_rx(b, 1'b0, 3);
        reg_rd(4'd1, st); check("status frame error", 32'(st), 32'h1F);
        reg_wr(4'd1, 8'h18);
        reg_rd(4'd1, st); check("status flags cleared", 32'(st), 32'h07);
        reg_pop(rd); check("rx byte kept over bad frame", 32'(rd), 32'(b3));
        reg_rd(4'd1, st); check("status after clear pop", 32'(st), 32'h03);

        set_div(7);
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (30) @(negedge clk);
        reg_rd(4'd1, st); check("glitch ignored", 32'(st), 32'h03);
        b = 8'($urandom);
        send_rx(b, 1'b1, 7);
        wait_rx_valid("rx valid after glitch");
        reg_pop(rd); check("rx data after glitch", 32'(rd), 32'(b));
        reg_wr(4'd4, 8'h00);
`else
        set_div(3);
        send_rx(8'h00, 1'b1, 3);
        reg_rd(4'd1, st); check("no rx status", 32'(st), 32'h03);
        reg_rd(4'd0, rd); check("no rx data", 32'(rd), 32'd0);
`endif

        d = 3;
        set_div(d);
        b = 8'($urandom) & 8'hF7;
        reg_wr(4'd0, b);
        @(posedge clk);
        @(posedge clk);
        repeat (4 * (d + 1) + 1) @(posedge clk);
        @(negedge clk); check("tx in data bit3", 32'(tx), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("tx after mid-frame reset", 32'(tx), 32'd1);
        reset = 1'b0;
        reg_rd(4'd1, st); check("status after mid-frame reset", 32'(st), 32'h03);
        reg_rd(4'd2, rd); check("div_lo after mid-frame reset", 32'(rd), 32'(RESET_DIV & 8'hFF));
        reg_rd(4'd3, rd); check("div_hi after mid-frame reset", 32'(rd), 32'(RESET_DIV >> 8));
        check_idle("tx quiet after reset", 40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
